// File: rtl/gemm_pkg.sv
// Shared types and tile geometry for the GEMM tile controller.
package gemm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } gemm_state_e;

    // Default tile geometry as log2 values; every tile dimension is a power of two.
    localparam int LOG2_M = 1;
    localparam int LOG2_K = 5;
    localparam int LOG2_N = 0;

endpackage

// File: rtl/gemm_loop_counter.sv
// Nested kt (inner) / nt (middle) / mt (outer) tile counter with last flags.
module gemm_loop_counter #(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             step,
    input  logic [Width-1:0] kt_num,
    input  logic [Width-1:0] nt_num,
    input  logic [Width-1:0] mt_num,
    output logic [Width-1:0] kt,
    output logic [Width-1:0] nt,
    output logic             kt_last,
    output logic             nt_last,
    output logic             all_last
);

    logic [Width-1:0] mt;
    logic             mt_last;

    // Counts are tile counts (never zero while stepping), so the last index is count-1.
    assign kt_last  = (kt == kt_num - Width'(1));
    assign nt_last  = (nt == nt_num - Width'(1));
    assign mt_last  = (mt == mt_num - Width'(1));
    assign all_last = kt_last && nt_last && mt_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kt <= '0;
            nt <= '0;
            mt <= '0;
        end else if (clear) begin
            kt <= '0;
            nt <= '0;
            mt <= '0;
        end else if (step) begin
            if (!kt_last) begin
                kt <= kt + Width'(1);
            end else begin
                kt <= '0;
                if (!nt_last) begin
                    nt <= nt + Width'(1);
                end else begin
                    nt <= '0;
                    mt <= mt_last ? '0 : mt + Width'(1);
                end
            end
        end
    end

endmodule

// File: rtl/gemm_tile_controller.sv
// Walks output tiles of C = A x B, issuing A/B reads per reduction step and a C write per tile.
module gemm_tile_controller
    import gemm_pkg::*;
#(
    parameter int M             = 1 << LOG2_M,
    parameter int K             = 1 << LOG2_K,
    parameter int N             = 1 << LOG2_N,
    parameter int SizeAddrWidth = 8,
    parameter int AddrWidth     = 6,
    parameter int AddrWidthC    = 9
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic [AddrWidthC-1:0]    sram_c_addr_o,
    output logic                     sram_c_we_o,
    output logic                     mac_valid_o,
    output logic                     mac_clr_o,
    output logic                     busy_o,
    output logic                     done_o,
    output gemm_state_e              state_dbg_o
);

    localparam int ShM = $clog2(M);
    localparam int ShK = $clog2(K);
    localparam int ShN = $clog2(N);

    // Handshake: start_i is a level sampled only in IDLE; done_o is a single-cycle
    // pulse and no back-pressure exists anywhere on the read or write path.

    gemm_state_e state_q, state_d;
    logic        drain_q;

    logic [SizeAddrWidth-1:0] mt_num_q, kt_num_q, nt_num_q;
    logic [SizeAddrWidth-1:0] mt_num_in, kt_num_in, nt_num_in;
    logic [SizeAddrWidth-1:0] kt, nt;
    logic                     kt_last, nt_last, all_last;
    logic                     size_zero, launch, issue, step;

    logic [AddrWidth-1:0]     a_base_q, kt_stride, nt_stride, nt_next;
    logic [AddrWidthC-1:0]    c_tile_q, c_addr_d1;
    logic                     we_d1;

    assign mt_num_in = M_size_i >> ShM;
    assign kt_num_in = K_size_i >> ShK;
    assign nt_num_in = N_size_i >> ShN;
    assign size_zero = (mt_num_in == '0) || (kt_num_in == '0) || (nt_num_in == '0);
    assign step      = issue && !all_last;
    assign state_dbg_o = state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == DRAIN);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = size_zero ? DONE : RUN;
            RUN:     if (all_last) state_d = DRAIN;
            DRAIN:   if (drain_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        issue  = 1'b0;
        launch = 1'b0;
        unique case (state_q)
            IDLE:  launch = start_i && !size_zero;
            RUN: begin
                busy_o = 1'b1;
                issue  = 1'b1;
            end
            DRAIN: busy_o = 1'b1;
            DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mt_num_q <= '0;
            kt_num_q <= '0;
            nt_num_q <= '0;
        end else if (launch) begin
            mt_num_q <= mt_num_in;
            kt_num_q <= kt_num_in;
            nt_num_q <= nt_num_in;
        end
    end

    gemm_loop_counter #(
        .Width(SizeAddrWidth)
    ) u_loop_counter (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .clear   (launch),
        .step    (step),
        .kt_num  (kt_num_q),
        .nt_num  (nt_num_q),
        .mt_num  (mt_num_q),
        .kt      (kt),
        .nt      (nt),
        .kt_last (kt_last),
        .nt_last (nt_last),
        .all_last(all_last)
    );

    // A walks mt*KT+kt via a row base; B strides by NT within a tile and restarts at nt+1.
    assign kt_stride = AddrWidth'(kt_num_q);
    assign nt_stride = AddrWidth'(nt_num_q);
    assign nt_next   = AddrWidth'(nt) + AddrWidth'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_base_q      <= '0;
            sram_a_addr_o <= '0;
            sram_b_addr_o <= '0;
            c_tile_q      <= '0;
        end else if (launch) begin
            a_base_q      <= '0;
            sram_a_addr_o <= '0;
            sram_b_addr_o <= '0;
            c_tile_q      <= '0;
        end else if (step) begin
            if (!kt_last) begin
                sram_a_addr_o <= sram_a_addr_o + AddrWidth'(1);
                sram_b_addr_o <= sram_b_addr_o + nt_stride;
            end else if (!nt_last) begin
                sram_a_addr_o <= a_base_q;
                sram_b_addr_o <= nt_next;
                c_tile_q      <= c_tile_q + AddrWidthC'(1);
            end else begin
                a_base_q      <= a_base_q + kt_stride;
                sram_a_addr_o <= a_base_q + kt_stride;
                sram_b_addr_o <= '0;
                c_tile_q      <= c_tile_q + AddrWidthC'(1);
            end
        end
    end

    // One cycle of SRAM read latency before the MAC, one more before the C write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mac_valid_o   <= 1'b0;
            mac_clr_o     <= 1'b0;
            we_d1         <= 1'b0;
            c_addr_d1     <= '0;
            sram_c_we_o   <= 1'b0;
            sram_c_addr_o <= '0;
        end else begin
            mac_valid_o <= issue;
            mac_clr_o   <= issue && (kt == '0);
            we_d1       <= issue && kt_last;
            c_addr_d1   <= c_tile_q;
            sram_c_we_o <= we_d1;
            if (we_d1) sram_c_addr_o <= c_addr_d1;
        end
    end

endmodule

// File: tb/tb_gemm_tile_controller.sv
// Directed and randomized bench for gemm_tile_controller against a loop-level schedule model.
module tb_gemm_tile_controller;
    import gemm_pkg::*;

    localparam int MaxCyc = 2048;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [7:0]  m_size, k_size, n_size;
    logic [5:0]  sram_a_addr, sram_b_addr;
    logic [8:0]  sram_c_addr;
    logic        sram_c_we, mac_valid, mac_clr, busy, done;
    gemm_state_e state_dbg;

    int checks   = 0;
    int failures = 0;

    logic [5:0] exp_a   [MaxCyc];
    logic [5:0] exp_b   [MaxCyc];
    logic       exp_v   [MaxCyc];
    logic       exp_clr [MaxCyc];
    logic       exp_we  [MaxCyc];
    logic       exp_busy[MaxCyc];
    logic       exp_done[MaxCyc];
    logic [8:0] exp_q[$];

    gemm_tile_controller dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .M_size_i     (m_size),
        .K_size_i     (k_size),
        .N_size_i     (n_size),
        .sram_a_addr_o(sram_a_addr),
        .sram_b_addr_o(sram_b_addr),
        .sram_c_addr_o(sram_c_addr),
        .sram_c_we_o  (sram_c_we),
        .mac_valid_o  (mac_valid),
        .mac_clr_o    (mac_clr),
        .busy_o       (busy),
        .done_o       (done),
        .state_dbg_o  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, sram_a_addr, 0);
        check({tag, "_b"}, sram_b_addr, 0);
        check({tag, "_c"}, sram_c_addr, 0);
        check({tag, "_we"}, sram_c_we, 0);
        check({tag, "_valid"}, mac_valid, 0);
        check({tag, "_clr"}, mac_clr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_state"}, state_dbg, IDLE);
    endtask

    // Cycle n is the interval after clock edge n-1; the start edge closes cycle 0.
    task automatic run_cfg(input string tag, input int ms, input int ks, input int ns,
                           input int rst_cyc, input int repulse_cyc);
        int mt_n, kt_n, nt_n, s_total, last_cyc, s, n_writes, n_done, n_exp_writes;
        logic [8:0] c_exp;
        mt_n = ms / 2;
        kt_n = ks / 32;
        nt_n = ns / 1;
        s_total = mt_n * kt_n * nt_n;
        n_exp_writes = (s_total == 0) ? 0 : mt_n * nt_n;
        for (int i = 0; i < MaxCyc; i++) begin
            exp_a[i] = '0; exp_b[i] = '0; exp_v[i] = 1'b0; exp_clr[i] = 1'b0;
            exp_we[i] = 1'b0; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
        end
        exp_q.delete();
        if (s_total == 0) begin
            exp_done[1] = 1'b1;
            last_cyc = 2;
        end else begin
            s = 0;
            for (int mt = 0; mt < mt_n; mt++)
                for (int nt = 0; nt < nt_n; nt++)
                    for (int kt = 0; kt < kt_n; kt++) begin
                        exp_a[s+1]   = 6'((mt * kt_n + kt) % 64);
                        exp_b[s+1]   = 6'((kt * nt_n + nt) % 64);
                        exp_v[s+2]   = 1'b1;
                        exp_clr[s+2] = (kt == 0);
                        if (kt == kt_n - 1) begin
                            exp_we[s+3] = 1'b1;
                            exp_q.push_back(9'((mt * nt_n + nt) % 512));
                        end
                        s++;
                    end
            for (int c = 1; c <= s_total + 2; c++) exp_busy[c] = 1'b1;
            exp_done[s_total + 3] = 1'b1;
            last_cyc = s_total + 4;
            for (int c = s_total + 1; c <= last_cyc; c++) begin
                exp_a[c] = exp_a[s_total];
                exp_b[c] = exp_b[s_total];
            end
        end

        @(negedge clk);
        m_size = 8'(ms); k_size = 8'(ks); n_size = 8'(ns);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        n_writes = 0;
        n_done = 0;
        for (int cyc = 1; cyc <= last_cyc; cyc++) begin
            if (cyc == repulse_cyc) begin
                start_i = 1'b1;
                m_size = 8'd32; k_size = 8'd32; n_size = 8'd32;
            end else begin
                start_i = 1'b0;
            end
            if (cyc == rst_cyc) begin
                rst_ni = 1'b0;
                #1;
                check_all_zero({tag, "_async_rst"});
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_ni = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    @(posedge clk); #1;
                    check({tag, "_post_rst_we"}, sram_c_we, 0);
                    check({tag, "_post_rst_valid"}, mac_valid, 0);
                end
                return;
            end
            check({tag, "_valid"}, mac_valid, exp_v[cyc]);
            check({tag, "_clr"}, mac_clr, exp_clr[cyc]);
            check({tag, "_we"}, sram_c_we, exp_we[cyc]);
            check({tag, "_busy"}, busy, exp_busy[cyc]);
            check({tag, "_done"}, done, exp_done[cyc]);
            if (s_total > 0) begin
                check({tag, "_a_addr"}, sram_a_addr, exp_a[cyc]);
                check({tag, "_b_addr"}, sram_b_addr, exp_b[cyc]);
            end
            if (exp_we[cyc] && exp_q.size() > 0) begin
                c_exp = exp_q.pop_front();
                check({tag, "_c_addr"}, sram_c_addr, c_exp);
            end
            if (sram_c_we === 1'b1) n_writes++;
            if (done === 1'b1) n_done++;
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        check({tag, "_write_count"}, n_writes, n_exp_writes);
        check({tag, "_done_pulses"}, n_done, 1);
        check({tag, "_exp_q_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int ms, ks, ns;
        rst_ni = 1'b0;
        start_i = 1'b0;
        m_size = '0; k_size = '0; n_size = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk); #1;
        check_all_zero("idle");

        run_cfg("cfg1", 4, 64, 16, -1, -1);
        run_cfg("cfg2", 16, 64, 4, -1, -1);
        run_cfg("cfg3", 32, 32, 32, -1, -1);
        run_cfg("zero_k", 4, 16, 16, -1, -1);
        run_cfg("repulse_run", 4, 64, 16, -1, 10);
        run_cfg("start_in_done", 4, 64, 16, -1, 67);
        run_cfg("mid_reset", 4, 64, 16, 20, -1);
        run_cfg("after_reset", 16, 64, 4, -1, -1);

        for (int r = 0; r < 6; r++) begin
            ms = $urandom_range(0, 24);
            ks = $urandom_range(0, 200);
            ns = $urandom_range(0, 24);
            run_cfg("rand", ms, ks, ns, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gemm_tile_controller.md
Name: gemm_tile_controller

Overview:
- Sequencing FSM for the tiled GEMM datapath. It walks the output tiles, each M rows by N columns, of C = A x B, and for every output tile it walks the K_size/K reduction steps.
- Per step it drives the SRAM A/B read addresses and the MAC-array valid and clear strobes. At the end of each tile it drives the SRAM C address and write enable.
- It sits inside gemm_accelerator_top, between the start/size configuration inputs and the MAC array and memories.

Parameters:
- M, 2, tile rows per A word / C word (power of two)
- K, 32, reduction elements per A/B word (power of two)
- N, 1, tile columns per B word / C word (power of two)
- SizeAddrWidth, 8, width of the size inputs and internal tile counters
- AddrWidth, 6, SRAM A/B address width
- AddrWidthC, 9, SRAM C address width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  start request; sampled only in IDLE
- M_size_i  in  SizeAddrWidth  matrix M dimension
- K_size_i  in  SizeAddrWidth  matrix K dimension
- N_size_i  in  SizeAddrWidth  matrix N dimension
- sram_a_addr_o  out  AddrWidth  A word address
- sram_b_addr_o  out  AddrWidth  B word address
- sram_c_addr_o  out  AddrWidthC  C word address
- sram_c_we_o  out  1  C write enable
- mac_valid_o  out  1  A/B read data on the SRAM outputs is valid this cycle
- mac_clr_o  out  1  with mac_valid_o: first reduction step; the accumulator loads the product instead of adding
- busy_o  out  1  high from RUN through DRAIN
- done_o  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, all counters 0.
- Tile counts are latched at start: MT=M_size_i/M, KT=K_size_i/K, NT=N_size_i/N. The divides are shifts; any remainder is discarded.
- Loop order: mt outer, nt middle, kt inner.
- Address generation:
  - sram_a_addr_o = mt*KT + kt
  - sram_b_addr_o = kt*NT + nt
  - sram_c_addr_o = mt*NT + nt
  - All three are built from incrementing and base-add registers; no multipliers.
  - Each is truncated to its address width; overflow wraps silently.
- SRAM read latency is 1 cycle.
- Pipeline: the address for step kt is issued in cycle t. In cycle t+1, mac_valid_o=1, and mac_clr_o=(kt==0). In cycle t+2 after the last kt of a tile, sram_c_we_o=1 with that tile's C address.
- Throughput: addresses are issued back to back across tile boundaries with no bubbles, so the controller produces one tile every KT cycles.
- State IDLE:
  - start_i=1 latches the sizes.
  - If MT, KT or NT is 0, go to DONE with no memory accesses.
  - Otherwise go to RUN.
  - The first address is issued in the cycle after the start edge.
- State RUN: issues one address pair per cycle. After issuing the final pair (mt=MT-1, nt=NT-1, kt=KT-1), go to DRAIN.
- State DRAIN: 2 cycles. It emits the final mac_valid_o and the final sram_c_we_o, then goes to DONE.
- State DONE: done_o=1 for one cycle, then return to IDLE.
- Inactive outputs: outside RUN and DRAIN, addresses hold their last value; mac_valid_o, mac_clr_o and sram_c_we_o are 0.
- Boundary conditions:
  - start_i while busy, or in DONE: ignored.
  - Size inputs changing mid-run: no effect, since the values were latched at start.
  - Reset mid-operation: immediate return to IDLE with reset output values. No further writes occur; a partially written C is acceptable.
  - KT=1: mac_clr_o accompanies every mac_valid_o, and sram_c_we_o is high on every cycle of the write stream.
- Total latency: done_o is asserted at cycle MT*NT*KT+3 after the start edge.

Decomposition:
- Package gemm_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - localparams log2(M), log2(K), log2(N)
- One sub-module, gemm_loop_counter: a nested three-level counter for kt, nt and mt. It has wrap/last flags and a step enable. It is instantiated once.
- Address arithmetic and the valid/write delay pipeline live in the top controller.

Test Plan:
- Config 1, M=4 K=64 N=16 (MT=2 KT=2 NT=16):
  - A addresses start 0,1,0,1; B addresses start 0,16,1,17.
  - 32 writes to C addresses 0..31 ascending at cycles 4,6,...,66.
  - mac_clr_o on odd valid cycles; done_o at cycle 67.
- Config 2, M=16 K=64 N=4 (MT=8 KT=2 NT=4):
  - 32 C writes at 0..31; A address reaches 15 on the final tile.
  - done_o at cycle 67.
- Config 3, M=K=N=32 (KT=1):
  - mac_clr_o equals mac_valid_o on every cycle; 512 consecutive writes at C addresses 0..511 in cycles 3..514.
  - done_o at cycle 515; the bench golden model matches C.
- Zero size, K_size=16:
  - done_o at cycle 1.
  - No mac_valid_o or sram_c_we_o ever; busy_o stays 0.
- start_i re-pulsed during RUN of config 1, with sizes changed to 32/32/32:
  - Run is unaffected; exactly 32 writes; a single done_o pulse.
- rst_ni low at cycle 20 of config 1:
  - All outputs 0 asynchronously; no further writes.
  - A following start with config 2 completes normally.
